ex_div_unit: RTL and testbench
==============================

Name: ex_div_unit

Overview:
Iterative multi-cycle divider in the EX stage. Consumes the operands that the ID/EX register delivers for DIV/DIVU. Returns {remainder, quotient} with a ready handshake.
The EX stage derives its upstream stall request from this block's busy state, so this is the return path that holds ID/EX while a divide completes.
Uses a radix-2 restoring shift-subtract algorithm, one quotient bit per cycle.

Parameters:
WIDTH, 32, operand width; the result is 2*WIDTH wide.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, synchronous, active-high.
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
opdata1_i  input  WIDTH  dividend.
opdata2_i  input  WIDTH  divisor.
start_i  input  1  divide request; held high by EX until ready_o is seen.
annul_i  input  1  cancel the in-flight divide (pipeline flush).
result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
ready_o  output  1  result valid.
busy_o  output  1  high in BYZERO/ON, and in FREE whenever start_i=1 and annul_i=0; combinational; the EX stall request uses it.

Behaviour:
- All state and outputs are registered except busy_o.
- Reset (rst=1 at a rising edge):
  - state=FREE, cnt=0.
  - result_o=0, ready_o=0, internal dividend/divisor registers cleared.
  - Reset overrides everything, including an in-flight divide.
- States: FREE, BYZERO, ON, END.
- FREE:
  - If start_i=1 and annul_i=0: capture the operands. In signed mode, take the absolute value (two's complement negate) of each negative operand.
  - Divisor==0 -> go to BYZERO. Otherwise go to ON with cnt=0, partial remainder=0, shift register=|dividend|.
  - Otherwise stay in FREE. ready_o=0, result_o=0.
- BYZERO: the next edge goes to END with result_o=0 and ready_o=1.
- ON:
  - If annul_i=1: go to FREE and discard all state; ready_o stays 0.
  - Else, while cnt<WIDTH, each edge does one step:
    - Shift {rem, q} left by 1.
    - Trial = rem - divisor. If the trial does not borrow, rem=trial and q[0]=1; else q[0]=0.
    - cnt++.
  - When cnt==WIDTH, the next edge applies sign fix-up and goes to END with ready_o=1:
    - Quotient is negated iff signed and the operand signs differ.
    - Remainder is negated iff signed and the dividend was negative.
- END:
  - ready_o=1; result_o holds.
  - When start_i=0 at an edge: go to FREE with ready_o=0 and result_o=0.
  - While start_i stays 1, END holds. A new divide requires start_i to drop for at least one edge.
- Latency, counting the accepting edge in FREE as edge 1:
  - Nonzero divisor: ready_o rises after edge WIDTH+2 (34 for WIDTH=32).
  - Zero divisor: ready_o rises after edge 2.
- Operands are captured at acceptance; later changes on opdata*_i are ignored.
- Signed overflow (-2^(WIDTH-1) / -1): quotient=0x80000000, remainder=0 (wraps, no trap).
- The unsigned datapath is a WIDTH+1-bit subtractor; there are no intermediate overflows.
- annul_i is ignored in BYZERO and END.
- annul_i together with start_i in FREE: the request is not accepted.

Test Plan:
1. Unsigned 100/7: start with signed=0 -> ready_o after edge 34 (counting the accepting edge as 1); result_o=0x00000002_0000000E. Drop start_i -> next edge ready_o=0, result_o=0.
2. Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
3. Divisor 0 (0x12345678/0) -> ready_o after edge 2; result_o=0. busy_o=1 for the accepting cycle and the BYZERO cycle only.
4. annul_i pulsed at edge 10 of a divide -> state FREE, ready_o never asserts. A new start of 0xFFFFFFFF/0x10 unsigned (no annul) -> result 0x0000000F_0FFFFFFF.
5. rst asserted at edge 20 of a divide -> next cycle ready_o=0, result_o=0. A fresh divide afterwards completes normally.
6. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. start_i held high in END for 5 cycles -> ready_o and result_o stable throughout.

Source files
------------

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per cycle; returns {remainder, quotient} with a ready flag.
module ex_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dsor_q, dsor_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       trial;

  assign abs_a = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs_b = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // shifted < 2*divisor, so bit WIDTH of the difference doubles as the borrow
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsor_q};

  assign busy_o = (state_q == ST_BYZERO) || (state_q == ST_ON) ||
                  ((state_q == ST_FREE) && start_i && !annul_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsor_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsor_q    <= dsor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsor_d    = dsor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      ST_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          dsor_d    = abs_b;
          quo_d     = abs_a;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_rem_d = signed_div_i && opdata1_i[WIDTH-1];
          state_d   = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
        end
      end
      ST_BYZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
        state_d  = ST_END;
      end
      ST_ON: begin
        if (annul_i) begin
          state_d   = ST_FREE;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = '0;
          dsor_d    = '0;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          ready_d   = 1'b0;
        end else if (cnt_q != CNT_W'(WIDTH)) begin
          quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d = {(neg_rem_q ? -rem_q : rem_q), (neg_quo_q ? -quo_q : quo_q)};
          ready_d  = 1'b1;
          state_d  = ST_END;
        end
      end
      ST_END: begin
        if (!start_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = ST_FREE;
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit with an arithmetic reference model and result scoreboard.
module tb_ex_div_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          signed_div;
  logic [W-1:0]  op1, op2;
  logic          start, annul;
  logic [2*W-1:0] result;
  logic          ready, busy;

  int compared   = 0;
  int mismatched = 0;
  logic [2*W-1:0] sb_q[$];

  always #5 clk = ~clk;

  ex_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .busy_o       (busy)
  );

  function automatic logic [2*W-1:0] model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    if (b == '0) return '0;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      sq = sa / sb;
      sr = sa % sb;
      return {sr[W-1:0], sq[W-1:0]};
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    uq = ua / ub;
    ur = ua % ub;
    return {ur[W-1:0], uq[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input string name, output logic [2*W-1:0] got);
    int edges;
    logic [2*W-1:0] exp;
    edges = 0;
    signed_div = s;
    op1 = a;
    op2 = b;
    start = 1'b1;
    sb_q.push_back(model(s, a, b));
    #1;
    check({name, " busy_accept"}, 64'(busy), 64'd1);
    while (edges < 100) begin
      tick;
      edges++;
      if (edges == 1) begin
        op1 = $urandom;
        op2 = $urandom;
      end
      if (ready) break;
      check({name, " busy_run"}, 64'(busy), 64'd1);
    end
    check({name, " latency"}, 64'(edges), 64'((b == '0) ? 2 : W + 2));
    got = result;
    exp = sb_q.pop_front();
    check({name, " result"}, got, exp);
    check({name, " busy_end"}, 64'(busy), 64'd0);
    for (int i = 0; i < hold; i++) begin
      tick;
      check({name, " hold_ready"}, 64'(ready), 64'd1);
      check({name, " hold_result"}, result, exp);
    end
    start = 1'b0;
    tick;
    check({name, " drop_ready"}, 64'(ready), 64'd0);
    check({name, " drop_result"}, result, 64'd0);
    $display("div %s s=%0d a=%h b=%h -> %h (exp %h) in %0d edges", name, s, a, b, got, exp, edges);
  endtask

  initial begin
    logic [2*W-1:0] got;
    bit seen;

    rst = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    signed_div = 1'b0;
    op1 = '0;
    op2 = '0;
    tick;
    tick;
    check("reset ready", 64'(ready), 64'd0);
    check("reset result", result, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick;

    run_div(1'b0, 32'd100, 32'd7, 0, "udiv_100_7", got);
    check("udiv_100_7 const", got, 64'h00000002_0000000E);

    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 0, "sdiv_m7_2", got);
    check("sdiv_m7_2 const", got, 64'hFFFFFFFF_FFFFFFFD);
    run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 0, "sdiv_7_m2", got);
    check("sdiv_7_m2 const", got, 64'h00000001_FFFFFFFD);
    run_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 0, "sdiv_m100_m7", got);

    run_div(1'b0, 32'h12345678, 32'h0, 0, "div_by_zero", got);

    // Annul mid-divide: the request must vanish with no ready.
    signed_div = 1'b0;
    op1 = 32'hDEADBEEF;
    op2 = 32'h3;
    start = 1'b1;
    repeat (9) tick;
    annul = 1'b1;
    start = 1'b0;
    tick;
    annul = 1'b0;
    check("annul busy_after", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      tick;
      if (ready) seen = 1'b1;
    end
    check("annul no_ready", 64'(seen), 64'd0);

    start = 1'b1;
    annul = 1'b1;
    #1;
    check("annul_free busy", 64'(busy), 64'd0);
    repeat (3) tick;
    check("annul_free ready", 64'(ready), 64'd0);
    check("annul_free busy_later", 64'(busy), 64'd0);
    start = 1'b0;
    annul = 1'b0;
    tick;

    run_div(1'b0, 32'hFFFFFFFF, 32'h10, 0, "udiv_ffff_10", got);
    check("udiv_ffff_10 const", got, 64'h0000000F_0FFFFFFF);

    // Reset mid-divide.
    signed_div = 1'b1;
    op1 = 32'h7654321;
    op2 = 32'h5;
    start = 1'b1;
    repeat (19) tick;
    rst = 1'b1;
    start = 1'b0;
    tick;
    rst = 1'b0;
    check("rst_mid ready", 64'(ready), 64'd0);
    check("rst_mid result", result, 64'd0);
    check("rst_mid busy", 64'(busy), 64'd0);
    run_div(1'b0, 32'd1000, 32'd33, 0, "after_rst", got);

    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 5, "sdiv_ovf", got);
    check("sdiv_ovf const", got, 64'h00000000_80000000);

    for (int i = 0; i < 6; i++) begin
      run_div(1'($urandom_range(0, 1)), $urandom, (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom,
              0, $sformatf("rand%0d", i), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
